tt_sweeper: RTL and testbench
=============================

# tt_sweeper

Hardware truth-table sweeper for small combinational functions. It drives every input combination of an N-input function onto a shared vector, waits a programmable settle time, and samples two function outputs (A and B) into truth-table registers. It then reports whether the two implementations are equivalent and the lowest differing minterm. It sits on the stimulus/response side of the combinational exercises, in silicon rather than in a bench loop.

## Interface
- `N`, default 3: number of function inputs; tables are `2**N` bits wide.
- `SETTLE`, default 1: cycles each input vector is held before sampling; legal range ≥ 1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a sweep when sampled high in IDLE.
- `abc`  out  N  input vector driven to both functions; MSB is `a`.
- `fa`  in  1  output of function A under test.
- `fb`  in  1  output of function B under test.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep ends.
- `table_a`  out  2**N  captured truth table of A; bit i is the output for `abc == i`.
- `table_b`  out  2**N  captured truth table of B.
- `equal`  out  1  high when no sampled index differed.
- `mis_valid`  out  1  at least one mismatch was seen.
- `mis_idx`  out  N  lowest index where `fa != fb`.

## Operation
- States:
  - IDLE: `busy=0`. `start=1` → SWEEP.
  - SWEEP: `busy=1`. Ends → IDLE.
  - There is no separate DONE state; `done` is a registered pulse.
- Start edge:
  - `idx←0`, `abc←0`, settle counter `←0`.
  - `table_a`, `table_b`, `mis_valid` and `mis_idx` cleared.
  - `equal←1`, `busy←1`.
- SWEEP:
  - The counter increments every cycle.
  - At the edge where the counter reaches `SETTLE`, `fa` and `fb` are sampled into bit `idx` of their tables. That edge is the sample edge.
  - On a sample edge with `fa != fb`:
    - `equal←0`.
    - If `mis_valid` is 0, set `mis_valid←1` and `mis_idx←idx`. Later mismatches do not overwrite it.
  - On a sample edge with `idx < 2**N-1`: `idx←idx+1`, `abc←idx+1`, counter `←0`.
  - On the sample edge with `idx == 2**N-1`: `busy←0`, `done←1` for one cycle, `abc←0`, state `←`IDLE.
- `start` is ignored while `busy=1`. `start` held high in IDLE after `done` launches a new sweep on the next edge.
- Results (`table_*`, `equal`, `mis_*`) hold until the next start edge or reset.
- Index arithmetic is N-bit unsigned. The last index is detected by comparison, never by wrap-around.

## Timing
- Reset values:
  - `abc=0`, `busy=0`, `done=0`, `table_a=0`, `table_b=0`, `mis_valid=0`, `mis_idx=0`.
  - `equal=0` (no sweep has run).
- Index k is driven for exactly `SETTLE` cycles. It is sampled at the edge `(k+1)*SETTLE` cycles after the start edge.
- Full-sweep latency: `done` is high in the cycle after the edge `2**N * SETTLE` cycles after the start edge. For the defaults that is 8 cycles.
- `fa`/`fb` are assumed stable by the sample edge. The block adds no synchronizers.
- Reset mid-sweep:
  - Aborts immediately. All outputs return to their reset values, with no `done` pulse.
  - A `start` in the same cycle as `reset` is ignored.

## Configuration
- `TT_EARLY_STOP_EN` defined:
  - The sweep ends at the sample edge of the first mismatch, with `done` pulsed and `busy` dropped on that edge.
  - Unsampled table bits remain 0.
- `TT_EARLY_STOP_EN` undefined: every sweep covers all `2**N` indices regardless of mismatches.

## Structure
- Package `tt_pkg`:
  - State enum (IDLE, SWEEP).
  - Function `tt_width(N)` returning `2**N`.
  - Default constants for `N` and `SETTLE`.
- Sub-module `tt_settle_timer`:
  - Ports: `clk`, `reset`, `clear`, `tick`.
  - Counts `SETTLE` cycles and pulses `tick` on the sample edge.
- The top level holds the FSM, the index register, the tables and the mismatch tracking.

## Test plan
- Both functions wired to `a & ~(b&c)`, defaults, `start` pulse → `table_a = table_b = 8'h70`, `equal=1`, `mis_valid=0`, `done` 8 cycles after the start edge.
- A = `a & ~(b&c)`, B = its complement → `table_b = 8'h8F`, `equal=0`, `mis_idx=0`. Without the macro: `done` at 8 cycles. With the macro: `done` at 1 cycle, `table_a=0`, `table_b=8'h01`.
- B differs from A only at index 5 (B = A XOR `abc==5`) → `mis_idx=5`. With the macro: `done` at 6 cycles, `table_a=8'h30`, `table_b=8'h10`, bits 7:6 of both tables 0.
- `SETTLE=3` → `abc` steps 0..7, each held 3 cycles; `done` 24 cycles after start.
- `start` reasserted at cycle 4 of a sweep → ignored; single `done` at cycle 8. `start` held high through `done` → a second sweep starts with tables cleared.
- `reset` asserted at cycle 3 of a sweep → next cycle all outputs at reset values, no `done`. A fresh `start` then completes normally.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and defaults for the truth-table sweeper.
// Optional build macro: TT_EARLY_STOP_EN (see tt_sweeper.sv).
package tt_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam int TT_N_DEFAULT      = 3;
  localparam int TT_SETTLE_DEFAULT = 1;

  // Truth-table width for an n-input function.
  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_sweeper_if.sv
// Stimulus/response bundle between the sweeper and the two functions under test.
// master is the sweeper side, slave is the functions/host side.
interface tt_sweeper_if
  import tt_pkg::*;
#(
  parameter int N = TT_N_DEFAULT
);

  localparam int W = tt_width(N);

  logic         start;
  logic [N-1:0] abc;
  logic         fa;
  logic         fb;
  logic         busy;
  logic         done;
  logic [W-1:0] table_a;
  logic [W-1:0] table_b;
  logic         equal;
  logic         mis_valid;
  logic [N-1:0] mis_idx;

  modport master (
    input  start, fa, fb,
    output abc, busy, done, table_a, table_b, equal, mis_valid, mis_idx
  );

  modport slave (
    output start, fa, fb,
    input  abc, busy, done, table_a, table_b, equal, mis_valid, mis_idx
  );

endinterface

// File: rtl/tt_settle_timer.sv
// Settle timer: counts SETTLE cycles per input vector and flags the sample edge.
// While clear is high the count is held at zero and tick stays low.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int SETTLE = TT_SETTLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] count;

  // tick is high in the cycle whose closing edge is the sample edge.
  assign tick = !clear && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/tt_sweeper.sv
// Truth-table sweeper: walks abc through every minterm, captures fa/fb tables,
// and reports equivalence plus the lowest differing minterm.
// Define TT_EARLY_STOP_EN to end the sweep at the first mismatch.
module tt_sweeper
  import tt_pkg::*;
#(
  parameter int N      = TT_N_DEFAULT,
  parameter int SETTLE = TT_SETTLE_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  tt_sweeper_if.master  bus
);

  localparam int           W        = tt_width(N);
  localparam logic [N-1:0] LAST_IDX = N'(W - 1);

  state_t       state;
  state_t       state_next;
  logic [N-1:0] idx;
  logic         tick;
  logic         sample_diff;
  logic         last_sample;
  logic         finish;
  logic         done_q;
  logic [W-1:0] table_a_q;
  logic [W-1:0] table_b_q;
  logic         equal_q;
  logic         mis_valid_q;
  logic [N-1:0] mis_idx_q;

  tt_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .tick  (tick)
  );

  assign sample_diff = bus.fa ^ bus.fb;
  assign last_sample = (idx == LAST_IDX);

`ifdef TT_EARLY_STOP_EN
  assign finish = tick && (last_sample || sample_diff);
`else
  assign finish = tick && last_sample;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SWEEP;
      SWEEP:   if (finish)    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // idx doubles as the driven vector, so it returns to zero when a sweep ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      done_q      <= 1'b0;
      table_a_q   <= '0;
      table_b_q   <= '0;
      equal_q     <= 1'b0;
      mis_valid_q <= 1'b0;
      mis_idx_q   <= '0;
    end else begin
      done_q <= finish;
      if (state == IDLE && bus.start) begin
        idx         <= '0;
        table_a_q   <= '0;
        table_b_q   <= '0;
        equal_q     <= 1'b1;
        mis_valid_q <= 1'b0;
        mis_idx_q   <= '0;
      end else if (tick) begin
        table_a_q[idx] <= bus.fa;
        table_b_q[idx] <= bus.fb;
        if (sample_diff) begin
          equal_q <= 1'b0;
          if (!mis_valid_q) begin
            mis_valid_q <= 1'b1;
            mis_idx_q   <= idx;
          end
        end
        idx <= finish ? '0 : idx + N'(1);
      end
    end
  end

  assign bus.abc       = idx;
  assign bus.busy      = (state == SWEEP);
  assign bus.done      = done_q;
  assign bus.table_a   = table_a_q;
  assign bus.table_b   = table_b_q;
  assign bus.equal     = equal_q;
  assign bus.mis_valid = mis_valid_q;
  assign bus.mis_idx   = mis_idx_q;

endmodule

// File: tb/tb_tt_sweeper.sv
// Bench for tt_sweeper: two instances (SETTLE=1 and SETTLE=3) share stimulus and
// are compared every cycle against a timeline model of the sweep.
module tb_tt_sweeper;

  localparam int N = 3;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] tab_a;
  logic [7:0] tab_b;

  int checks = 0;
  int errors = 0;

  tt_sweeper_if #(.N(N)) bus1 ();
  tt_sweeper_if #(.N(N)) bus3 ();

  assign bus1.start = start;
  assign bus3.start = start;
  assign bus1.fa    = tab_a[bus1.abc];
  assign bus1.fb    = tab_b[bus1.abc];
  assign bus3.fa    = tab_a[bus3.abc];
  assign bus3.fb    = tab_b[bus3.abc];

  tt_sweeper #(.N(N), .SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  tt_sweeper #(.N(N), .SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;

  // Model state per lane: lane 0 is SETTLE=1, lane 1 is SETTLE=3.
  int         settle_of [2] = '{1, 3};
  bit         m_active  [2];
  bit         m_ran     [2];
  bit         m_done    [2];
  int         m_t       [2];
  int         m_stop    [2];
  logic [7:0] m_ta      [2];
  logic [7:0] m_tb      [2];

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int stop_time(input logic [7:0] a, input logic [7:0] b, input int s);
`ifdef TT_EARLY_STOP_EN
    if ((a ^ b) != 8'h00) return (lowest(a ^ b) + 1) * s;
`endif
    return W * s;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the timeline model on the edge just seen, then compare both lanes.
  initial begin
    bit         sr, ss;
    logic [7:0] sa, sb;
    forever begin
      @(posedge clk);
      sr = reset; ss = start; sa = tab_a; sb = tab_b;
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (sr) begin
          m_active[l] = 0; m_ran[l] = 0; m_done[l] = 0; m_t[l] = 0;
        end else if (m_active[l]) begin
          m_t[l]++;
          m_done[l] = (m_t[l] == m_stop[l]);
          if (m_done[l]) m_active[l] = 0;
        end else begin
          m_done[l] = 0;
          if (ss) begin
            m_active[l] = 1; m_ran[l] = 1; m_t[l] = 0;
            m_ta[l] = sa; m_tb[l] = sb;
            m_stop[l] = stop_time(sa, sb, settle_of[l]);
          end
        end
      end
      for (int l = 0; l < 2; l++) begin
        int         n;
        logic [7:0] mask, ea, eb, diff;
        logic [2:0] eabc;
        n    = m_active[l] ? m_t[l] / settle_of[l] : (m_ran[l] ? m_stop[l] / settle_of[l] : 0);
        mask = (n >= 8) ? 8'hFF : 8'((1 << n) - 1);
        ea   = m_ta[l] & mask;
        eb   = m_tb[l] & mask;
        if (!m_ran[l]) begin ea = 8'h00; eb = 8'h00; end
        diff = ea ^ eb;
        eabc = m_active[l] ? 3'(m_t[l] / settle_of[l]) : 3'd0;
        if (l == 0) begin
          check_output("s1.busy", 32'(bus1.busy), 32'(m_active[0]));
          check_output("s1.done", 32'(bus1.done), 32'(m_done[0]));
          check_output("s1.abc", 32'(bus1.abc), 32'(eabc));
          check_output("s1.table_a", 32'(bus1.table_a), 32'(ea));
          check_output("s1.table_b", 32'(bus1.table_b), 32'(eb));
          check_output("s1.equal", 32'(bus1.equal), 32'(m_ran[0] && diff == 8'h00));
          check_output("s1.mis_valid", 32'(bus1.mis_valid), 32'(diff != 8'h00));
          check_output("s1.mis_idx", 32'(bus1.mis_idx), 32'(lowest(diff)));
        end else begin
          check_output("s3.busy", 32'(bus3.busy), 32'(m_active[1]));
          check_output("s3.done", 32'(bus3.done), 32'(m_done[1]));
          check_output("s3.abc", 32'(bus3.abc), 32'(eabc));
          check_output("s3.table_a", 32'(bus3.table_a), 32'(ea));
          check_output("s3.table_b", 32'(bus3.table_b), 32'(eb));
          check_output("s3.equal", 32'(bus3.equal), 32'(m_ran[1] && diff == 8'h00));
          check_output("s3.mis_valid", 32'(bus3.mis_valid), 32'(diff != 8'h00));
          check_output("s3.mis_idx", 32'(bus3.mis_idx), 32'(lowest(diff)));
        end
      end
    end
  end

  // One start pulse, then count edges until each lane's done (bounded).
  task automatic apply_stimulus(output int lat1, output int lat3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat1 = -1; lat3 = -1;
    for (int c = 1; c <= 200 && (lat1 < 0 || lat3 < 0); c++) begin
      @(posedge clk); #1;
      if (lat1 < 0 && bus1.done) lat1 = c;
      if (lat3 < 0 && bus3.done) lat3 = c;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((bus1.busy || bus3.busy) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    check_output("idle_timeout", 32'(bus1.busy || bus3.busy), 32'd0);
  endtask

  initial begin
    int lat1, lat3, pulses;
    reset = 1'b1; start = 1'b0; tab_a = 8'h70; tab_b = 8'h70;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_output("rst.equal", 32'(bus1.equal), 32'd0);

    // Identical functions a & ~(b&c).
    apply_stimulus(lat1, lat3);
    check_output("eq.lat1", 32'(lat1), 32'd8);
    check_output("eq.lat3", 32'(lat3), 32'd24);
    check_output("eq.table_a", 32'(bus1.table_a), 32'h70);
    check_output("eq.table_b", 32'(bus1.table_b), 32'h70);
    check_output("eq.equal", 32'(bus1.equal), 32'd1);
    check_output("eq.mis_valid", 32'(bus1.mis_valid), 32'd0);

    // B is the complement of A.
    tab_b = 8'h8F;
    apply_stimulus(lat1, lat3);
    check_output("cmp.equal", 32'(bus1.equal), 32'd0);
    check_output("cmp.mis_idx", 32'(bus1.mis_idx), 32'd0);
`ifdef TT_EARLY_STOP_EN
    check_output("cmp.lat1", 32'(lat1), 32'd1);
    check_output("cmp.lat3", 32'(lat3), 32'd3);
    check_output("cmp.table_a", 32'(bus1.table_a), 32'h00);
    check_output("cmp.table_b", 32'(bus1.table_b), 32'h01);
`else
    check_output("cmp.lat1", 32'(lat1), 32'd8);
    check_output("cmp.table_b", 32'(bus1.table_b), 32'h8F);
`endif

    // B differs from A only at index 5.
    tab_b = 8'h50;
    apply_stimulus(lat1, lat3);
    check_output("m5.mis_idx", 32'(bus1.mis_idx), 32'd5);
    check_output("m5.mis_valid", 32'(bus1.mis_valid), 32'd1);
`ifdef TT_EARLY_STOP_EN
    check_output("m5.lat1", 32'(lat1), 32'd6);
    check_output("m5.lat3", 32'(lat3), 32'd18);
    check_output("m5.table_a", 32'(bus1.table_a), 32'h30);
    check_output("m5.table_b", 32'(bus1.table_b), 32'h10);
`else
    check_output("m5.lat1", 32'(lat1), 32'd8);
    check_output("m5.table_b", 32'(bus1.table_b), 32'h50);
`endif

    // start re-asserted mid-sweep is ignored: one done from lane 1.
    tab_b = 8'h70;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      start = (c == 4);
      @(posedge clk); #1;
      if (bus1.done) pulses++;
    end
    start = 1'b0;
    check_output("restart.pulses", 32'(pulses), 32'd1);
    wait_idle();

    // start held high through done relaunches a sweep.
    start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check_output("held.busy_again", 32'(bus1.busy), 32'd1);
    start = 1'b0;
    wait_idle();

    // Reset at cycle 3 of a sweep, together with start.
    tab_b = 8'h8F;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check_output("rst.busy", 32'(bus1.busy), 32'd0);
    check_output("rst.done", 32'(bus1.done), 32'd0);
    check_output("rst.table_b", 32'(bus1.table_b), 32'h00);
    tab_b = 8'h70;
    apply_stimulus(lat1, lat3);
    check_output("post_rst.lat1", 32'(lat1), 32'd8);
    check_output("post_rst.equal", 32'(bus1.equal), 32'd1);

    // Random function pairs with random idle gaps.
    for (int k = 0; k < 12; k++) begin
      tab_a = 8'($urandom);
      tab_b = ($urandom_range(0, 2) == 0) ? tab_a : 8'($urandom);
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      apply_stimulus(lat1, lat3);
      check_output("rand.done_seen", 32'(lat1 > 0 && lat3 > 0), 32'd1);
    end

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
